// File: rtl/fifo_sync_counted.sv
// fifo_sync_counted: single-clock FIFO of any depth with occupancy count, programmable thresholds, sticky errors and flush
// clk, rst_n (async, active-low); flush empties the FIFO; clear_errors drops the sticky flags
// af_thresh/ae_thresh: runtime thresholds for prog_full (count >= af) and prog_empty (count <= ae)
// write side: wen, wdata -> full, almost_full, prog_full, overflow
// read side: ren -> rdata, empty, almost_empty, prog_empty, underflow; count is the occupancy
module fifo_sync_counted #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH = 24,
  parameter int pFALLTHROUGH = 0,
  localparam int pCW = $clog2(pDEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   clear_errors,
  input  logic [pCW-1:0]         af_thresh,
  input  logic [pCW-1:0]         ae_thresh,
  input  logic                   wen,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   full,
  output logic                   almost_full,
  output logic                   prog_full,
  output logic                   overflow,
  input  logic                   ren,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   prog_empty,
  output logic                   underflow,
  output logic [pCW-1:0]         count
);
  localparam int pAW = $clog2(pDEPTH);
  localparam logic [pAW-1:0] pLAST = pAW'(pDEPTH - 1);
  logic [pDATA_WIDTH-1:0] mem [pDEPTH];
  logic [pAW-1:0] wptr, rptr;
  logic wr_acc, rd_acc;
  assign full = count == pCW'(pDEPTH);
  assign almost_full = count >= pCW'(pDEPTH - 1);
  assign prog_full = count >= af_thresh;
  assign empty = count == '0;
  assign almost_empty = count <= pCW'(1);
  assign prog_empty = count <= ae_thresh;
  assign wr_acc = wen && !full && !flush;
  assign rd_acc = ren && !empty && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // a fresh error in the same cycle as clear_errors keeps the flag set
      overflow <= (overflow && !clear_errors) || (wen && full && !flush);
      underflow <= (underflow && !clear_errors) || (ren && empty && !flush);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        count <= '0;
      end else begin
        if (wr_acc) wptr <= wptr == pLAST ? '0 : wptr + 1'b1;
        if (rd_acc) rptr <= rptr == pLAST ? '0 : rptr + 1'b1;
        count <= count + pCW'(wr_acc) - pCW'(rd_acc);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wdata;
  end
  if (pFALLTHROUGH != 0) begin : g_fwft
    assign rdata = mem[rptr];
  end else begin : g_reg
    logic [pDATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem[rptr];
    end
    assign rdata = rdata_q;
  end
endmodule

// File: tb/tb_fifo_sync_counted.sv
// tb_fifo_sync_counted: randomized and directed checks of fifo_sync_counted against a queue model
module tb_fifo_sync_counted;
  localparam int W = 8, D = 24, CW = 5;
  logic clk = 0, rst_n = 0, flush = 0, clear_errors = 0, wen = 0, ren = 0;
  logic [CW-1:0] af_thresh = 20, ae_thresh = 3;
  logic [W-1:0] wdata = 0;
  logic full, almost_full, prog_full, overflow, empty, almost_empty, prog_empty, underflow;
  logic [W-1:0] rdata;
  logic [CW-1:0] count;
  logic f_full, f_almost_full, f_prog_full, f_overflow, f_empty, f_almost_empty, f_prog_empty, f_underflow;
  logic [W-1:0] f_rdata;
  logic [CW-1:0] f_count;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic m_ovf = 0, m_udf = 0;
  logic [W-1:0] m_rdata = 0;
  fifo_sync_counted #(.pDATA_WIDTH(W), .pDEPTH(D), .pFALLTHROUGH(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clear_errors(clear_errors),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .wen(wen), .wdata(wdata),
    .full(full), .almost_full(almost_full), .prog_full(prog_full), .overflow(overflow),
    .ren(ren), .rdata(rdata), .empty(empty), .almost_empty(almost_empty),
    .prog_empty(prog_empty), .underflow(underflow), .count(count));
  fifo_sync_counted #(.pDATA_WIDTH(W), .pDEPTH(D), .pFALLTHROUGH(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clear_errors(clear_errors),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .wen(wen), .wdata(wdata),
    .full(f_full), .almost_full(f_almost_full), .prog_full(f_prog_full), .overflow(f_overflow),
    .ren(ren), .rdata(f_rdata), .empty(f_empty), .almost_empty(f_almost_empty),
    .prog_empty(f_prog_empty), .underflow(f_underflow), .count(f_count));
  always #5 clk = ~clk;
  task automatic tick();
    bit fl, em, wa, ra;
    fl = q.size() == D;
    em = q.size() == 0;
    wa = wen && !fl && !flush;
    ra = ren && !em && !flush;
    m_ovf = (m_ovf && !clear_errors) || (wen && fl && !flush);
    m_udf = (m_udf && !clear_errors) || (ren && em && !flush);
    if (flush) q.delete();
    else begin
      if (ra) m_rdata = q.pop_front();
      if (wa) q.push_back(wdata);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wen = 0;
    ren = 0;
    flush = 0;
    clear_errors = 0;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({count, full, almost_full, empty, almost_empty, overflow, underflow} !== {5'd0, 6'b001100}) begin
      errors++;
      $display("FAIL reset_status got cnt=%0d f=%b af=%b e=%b ae=%b o=%b u=%b exp cnt=0 001100",
               count, full, almost_full, empty, almost_empty, overflow, underflow);
    end
    checks++;
    if (rdata !== 8'h00 || f_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_rdata got rdata=%h fcnt=%0d exp 00 0", rdata, f_count);
    end
    #1 rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) begin
      wen = 1;
      wdata = W'(i);
      tick();
    end
    checks++;
    if ({full, count} !== {1'b1, 5'd24}) begin
      errors++;
      $display("FAIL fill_full got full=%b cnt=%0d exp 1 24", full, count);
    end
    wdata = 8'hEE;
    tick();
    wen = 0;
    checks++;
    if ({overflow, count} !== {1'b1, 5'd24}) begin
      errors++;
      $display("FAIL overflow_write got ovf=%b cnt=%0d exp 1 24", overflow, count);
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (f_rdata !== W'(i)) begin
        errors++;
        $display("FAIL fwft_head got %h exp %h", f_rdata, W'(i));
      end
      ren = 1;
      tick();
      checks++;
      if (rdata !== W'(i)) begin
        errors++;
        $display("FAIL drain_order got %h exp %h", rdata, W'(i));
      end
    end
    ren = 0;
    clear_errors = 1;
    tick();
    clear_errors = 0;
    checks++;
    if ({empty, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL drain_empty_clear got e=%b ovf=%b exp 1 0", empty, overflow);
    end
  endtask
  task automatic test_simul();
    for (int i = 0; i < D; i++) begin
      wen = 1;
      wdata = W'(100 + i);
      tick();
    end
    ren = 1;
    wdata = 8'h55;
    #1;
    checks++;
    if ({full, count} !== {1'b1, 5'd24}) begin
      errors++;
      $display("FAIL full_both_pre got full=%b cnt=%0d exp 1 24", full, count);
    end
    tick();
    checks++;
    if ({count, rdata, overflow} !== {5'd23, 8'd100, 1'b1}) begin
      errors++;
      $display("FAIL full_both got cnt=%0d rdata=%0d ovf=%b exp 23 100 1", count, rdata, overflow);
    end
    wen = 0;
    for (int i = 0; i < D - 1; i++) tick();
    wen = 1;
    wdata = 8'd77;
    tick();
    checks++;
    if ({count, underflow, rdata} !== {5'd1, 1'b1, 8'd123}) begin
      errors++;
      $display("FAIL empty_both got cnt=%0d udf=%b rdata=%0d exp 1 1 123", count, underflow, rdata);
    end
    idle();
    clear_errors = 1;
    tick();
    clear_errors = 0;
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL clear_errors got ovf=%b udf=%b exp 0 0", overflow, underflow);
    end
    ren = 1;
    tick();
    ren = 0;
    checks++;
    if ({rdata, empty} !== {8'd77, 1'b1}) begin
      errors++;
      $display("FAIL empty_both_data got %0d e=%b exp 77 1", rdata, empty);
    end
  endtask
  task automatic test_thresh();
    af_thresh = 20;
    ae_thresh = 3;
    for (int i = 1; i <= D; i++) begin
      wen = 1;
      wdata = W'($urandom);
      tick();
      checks++;
      if ({prog_full, prog_empty} !== {i >= 20, i <= 3}) begin
        errors++;
        $display("FAIL thresh_fill n=%0d got pf=%b pe=%b exp %b %b", i, prog_full, prog_empty, i >= 20, i <= 3);
      end
    end
    wen = 0;
    ae_thresh = 24;
    #1;
    checks++;
    if (prog_empty !== 1'b1) begin
      errors++;
      $display("FAIL ae_at_depth got %b exp 1", prog_empty);
    end
    ae_thresh = 23;
    #1;
    checks++;
    if (prog_empty !== 1'b0) begin
      errors++;
      $display("FAIL ae_below_depth got %b exp 0", prog_empty);
    end
    ae_thresh = 3;
    for (int i = D - 1; i >= 0; i--) begin
      ren = 1;
      tick();
      checks++;
      if ({prog_full, prog_empty} !== {i >= 20, i <= 3}) begin
        errors++;
        $display("FAIL thresh_drain n=%0d got pf=%b pe=%b exp %b %b", i, prog_full, prog_empty, i >= 20, i <= 3);
      end
    end
    ren = 0;
    af_thresh = 0;
    #1;
    checks++;
    if (prog_full !== 1'b1) begin
      errors++;
      $display("FAIL af_zero got %b exp 1", prog_full);
    end
    af_thresh = 20;
  endtask
  task automatic test_flush();
    for (int i = 0; i < 10; i++) begin
      wen = 1;
      wdata = W'(i);
      tick();
    end
    flush = 1;
    wdata = 8'd99;
    tick();
    idle();
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush got cnt=%0d e=%b exp 0 1", count, empty);
    end
    wen = 1;
    wdata = 8'h3C;
    tick();
    wen = 0;
    checks++;
    if ({count, f_rdata} !== {5'd1, 8'h3C}) begin
      errors++;
      $display("FAIL flush_new_fwft got cnt=%0d rdata=%h exp 1 3c", count, f_rdata);
    end
    ren = 1;
    tick();
    ren = 0;
    checks++;
    if ({rdata, empty} !== {8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL flush_new_read got %h e=%b exp 3c 1", rdata, empty);
    end
  endtask
  task automatic test_fwft();
    wen = 1;
    wdata = 8'hA5;
    tick();
    wen = 0;
    checks++;
    if ({f_rdata, f_empty} !== {8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL fwft_first got rdata=%h e=%b exp a5 0", f_rdata, f_empty);
    end
    ren = 1;
    tick();
    ren = 0;
    checks++;
    if ({f_empty, rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL fwft_read got e=%b rdata=%h exp 1 a5", f_empty, rdata);
    end
  endtask
  task automatic test_random();
    int pw, n;
    for (int c = 0; c < 3000; c++) begin
      pw = ((c / 300) % 2) ? 25 : 75;
      if (c % 50 == 0) begin
        af_thresh = CW'($urandom_range(0, 31));
        ae_thresh = CW'($urandom_range(0, 31));
      end
      wen = $urandom_range(0, 99) < pw;
      ren = $urandom_range(0, 99) < 100 - pw;
      flush = $urandom_range(0, 199) == 0;
      clear_errors = $urandom_range(0, 29) == 0;
      wdata = W'($urandom);
      tick();
      n = q.size();
      checks++;
      if ({count, f_count} !== {CW'(n), CW'(n)}) begin
        errors++;
        $display("FAIL rand_count c=%0d got %0d/%0d exp %0d", c, count, f_count, n);
      end
      checks++;
      if ({full, almost_full, prog_full, overflow, empty, almost_empty, prog_empty, underflow} !==
          {n == D, n >= D - 1, n >= int'(af_thresh), m_ovf, n == 0, n <= 1, n <= int'(ae_thresh), m_udf}) begin
        errors++;
        $display("FAIL rand_status c=%0d got %b exp %b", c,
                 {full, almost_full, prog_full, overflow, empty, almost_empty, prog_empty, underflow},
                 {n == D, n >= D - 1, n >= int'(af_thresh), m_ovf, n == 0, n <= 1, n <= int'(ae_thresh), m_udf});
      end
      checks++;
      if (rdata !== m_rdata) begin
        errors++;
        $display("FAIL rand_rdata c=%0d got %h exp %h", c, rdata, m_rdata);
      end
      if (n > 0) begin
        checks++;
        if (f_rdata !== q[0]) begin
          errors++;
          $display("FAIL rand_fwft c=%0d got %h exp %h", c, f_rdata, q[0]);
        end
      end
    end
    idle();
    af_thresh = 20;
    ae_thresh = 3;
  endtask
  task automatic test_async_reset();
    flush = 1;
    tick();
    flush = 0;
    wen = 1;
    for (int i = 0; i < D + 1; i++) begin
      wdata = W'(i);
      tick();
    end
    wen = 0;
    ren = 1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if ({count, overflow} !== {5'd12, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d ovf=%b exp 12 1", count, overflow);
    end
    wen = 1;
    #3 rst_n = 0;
    #1;
    checks++;
    if ({count, f_count, empty, full, overflow, underflow, rdata} !== {5'd0, 5'd0, 4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d fcnt=%0d e=%b f=%b o=%b u=%b rdata=%h exp 0 0 1 0 0 0 00",
               count, f_count, empty, full, overflow, underflow, rdata);
    end
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_rdata = 0;
    idle();
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    wen = 1;
    wdata = 8'h6B;
    tick();
    wen = 0;
    ren = 1;
    tick();
    ren = 0;
    checks++;
    if ({rdata, empty} !== {8'h6B, 1'b1}) begin
      errors++;
      $display("FAIL post_reset got %h e=%b exp 6b 1", rdata, empty);
    end
  endtask
  initial begin
    test_reset();
    test_fill_drain();
    test_simul();
    test_thresh();
    test_flush();
    test_fwft();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
